rgb2yuv_frame_arbiter: RTL and testbench
========================================

// Module: rgb2yuv_frame_arbiter
// PURPOSE
//  Shares one rgb2yuv converter between two RGB pixel streams, e.g. two sensor pipes.
//  Ownership is granted per frame, never per pixel, so converter output frames are never interleaved.
//  Arbitration is round-robin between the streams.
//  The block also applies the per-stream CSC enable, frozen at grant for the whole frame.
//  It aborts a frame whose owner stalls.
//  Sits directly in front of rgb2yuv; conv_* outputs drive its dvi/dtypei/r/g/b/meta_datai/enable.
// PARAMETERS
//  PIXEL_WIDTH   8     width of each colour component
//  IDLE_TIMEOUT  1024  consecutive owner-idle cycles mid-frame before abort (>=2)
// PORTS
//  clk            in   1              single clock; all logic on posedge clk
//  reset          in   1              asynchronous, active-high reset
//  csc_en         in   2              bit k = rgb2yuv enable for frames of stream k
//  s0_dv/s1_dv    in   1              stream k beat valid
//  s0_rdy/s1_rdy  out  1              stream k beat accepted this cycle (combinational)
//  sK_sof,sK_eof  in   1              beat is first / last pixel of frame (may both be 1)
//  sK_dtype       in   `DTYPE_WIDTH   data type, passed through
//  sK_r,sK_g,sK_b in   PIXEL_WIDTH    pixel components
//  sK_meta        in   16             meta data, passed through
//  conv_dv        out  1              to rgb2yuv dvi
//  conv_dtype     out  `DTYPE_WIDTH   to rgb2yuv dtypei
//  conv_r/g/b     out  PIXEL_WIDTH    to rgb2yuv r/g/b
//  conv_meta      out  16             to rgb2yuv meta_datai
//  conv_enable    out  1              to rgb2yuv enable
//  conv_owner     out  1              stream id aligned with conv_* inputs
//  yuv_owner      out  1              conv_owner delayed 1 cycle, aligned with rgb2yuv outputs
//  frame_abort    out  1              1-cycle pulse when a frame is aborted by timeout
//  frame_cnt0/1   out  16             completed (eof-accepted) frames per stream, wrap at 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; last_owner=1 (stream 0 wins first); timeout counter 0.
//  States
//   IDLE: no frame owner.
//    - A beat with dv=1 and sof=0 is dropped (rdy=1, not forwarded); this resyncs the stream.
//    - sof beat(s): winner = the only requester, or the stream != last_owner if both request.
//    - Winner: rdy=1, beat forwarded, enable_q<=csc_en[winner], go OWN_k.
//    - Loser: rdy=0; it holds its beat.
//    - If the winning beat also has eof: stay IDLE, last_owner<=winner, frame_cnt++.
//   OWN_k: sk_rdy=1; other stream rdy=0 (all its beats stall, incl. sof).
//    - Accepted beat with eof: go IDLE, last_owner<=k, frame_cnt_k++.
//    - Mid-frame sof from owner: forwarded as-is; no state change.
//  Forwarding: conv_dv <= (accepted && forwarded beat); conv_* data regs load only on accepted beats.
//   conv_enable=enable_q; conv_owner updated with each forwarded beat.
//   Latency: stream beat -> conv_* = 1 cycle; -> rgb2yuv output = 2 cycles.
//  Timeout: in OWN_k, cnt increments each cycle with sk_dv=0 and clears on sk_dv=1.
//   When cnt==IDLE_TIMEOUT-1 with sk_dv=0:
//    - go IDLE, frame_abort=1 for one cycle, last_owner<=k, frame_cnt unchanged, cnt<=0.
//    - No beat is forwarded in the abort cycle.
//  Reset asserted mid-frame: immediate return to reset values; the partial frame is lost.
//   After release, the stream resyncs at its next sof.
//  Pure routing: no arithmetic on pixel data; counters are unsigned 16b wrapping.
// TESTING
//  1 Reset: s0 sof+3 beats+eof (R=G=B=0x80, csc_en=2'b01)
//     -> rdy0 each cycle; conv_dv 1 cycle later, conv_enable=1, conv_owner=0;
//     -> frame_cnt0=1, back to IDLE.
//  2 Simultaneous sof on s0,s1 after reset -> s0 granted, s1_rdy=0 until s0 eof;
//     -> next cycle s1 granted; then both sof again -> s0 (round-robin).
//  3 s1 non-sof beats in IDLE -> rdy1=1, conv_dv=0 (dropped);
//     -> s1 sof then accepted with csc_en[1]=0 -> conv_enable=0 for whole frame despite csc_en toggling mid-frame.
//  4 IDLE_TIMEOUT=8: s0 sof then dv=0 for 8 cycles -> frame_abort pulse on 8th idle cycle, IDLE, frame_cnt0 unchanged;
//     -> pending s1 sof granted next cycle.
//  5 Single-beat frame (sof=eof=1) on s0 -> forwarded, frame_cnt0+1, state stays IDLE;
//     -> next s0 sof vs s1 sof -> s1 wins.
//  6 Assert reset mid-frame in OWN_1 -> all outputs 0, conv_dv=0;
//     -> after release, owner's continuing non-sof beats are dropped until its next sof.

Source files
------------

// File: rtl/rgb2yuv_frame_arbiter_if.sv
// ---------------------------------------------------------------------------
// rgb2yuv_frame_arbiter_if
//   One RGB pixel stream with a valid/ready beat handshake and frame markers.
//   master : stream source (drives beat fields, samples rdy)
//   slave  : stream sink   (samples beat fields, drives rdy)
//   Signals: dv (beat valid), rdy (beat accepted this cycle), sof/eof (first /
//   last pixel of frame), dtype (data type), r/g/b (pixel), meta (side data).
// ---------------------------------------------------------------------------
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif

interface rgb2yuv_frame_arbiter_if #(
  parameter int PIXEL_WIDTH = 8
);
  logic                    dv;
  logic                    rdy;
  logic                    sof;
  logic                    eof;
  logic [`DTYPE_WIDTH-1:0] dtype;
  logic [PIXEL_WIDTH-1:0]  r;
  logic [PIXEL_WIDTH-1:0]  g;
  logic [PIXEL_WIDTH-1:0]  b;
  logic [15:0]             meta;

  modport master (output dv, sof, eof, dtype, r, g, b, meta, input  rdy);
  modport slave  (input  dv, sof, eof, dtype, r, g, b, meta, output rdy);
endinterface

// File: rtl/rgb2yuv_frame_arbiter.sv
// ---------------------------------------------------------------------------
// rgb2yuv_frame_arbiter
//   Shares one rgb2yuv converter between two RGB pixel streams. Ownership is
//   granted per frame with round-robin between the streams, so converter
//   output frames never interleave. The CSC enable of the owner is frozen at
//   grant, and a frame whose owner stays idle for IDLE_TIMEOUT cycles is
//   aborted.
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   csc_en[1:0]        bit k = converter enable for frames of stream k
//   s0, s1             pixel streams (slave side; rdy is combinational)
//   conv_*             registered beat towards rgb2yuv (1 cycle latency)
//   conv_enable        enable latched at frame grant
//   conv_owner         stream id aligned with conv_* beat
//   yuv_owner          conv_owner delayed one cycle (aligned with rgb2yuv out)
//   frame_abort        one-cycle pulse in the cycle a frame times out
//   frame_cnt0/1       completed frames per stream, 16-bit wrapping
// ---------------------------------------------------------------------------
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif

module rgb2yuv_frame_arbiter #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               csc_en,
  rgb2yuv_frame_arbiter_if.slave   s0,
  rgb2yuv_frame_arbiter_if.slave   s1,
  output logic                     conv_dv,
  output logic [`DTYPE_WIDTH-1:0]  conv_dtype,
  output logic [PIXEL_WIDTH-1:0]   conv_r,
  output logic [PIXEL_WIDTH-1:0]   conv_g,
  output logic [PIXEL_WIDTH-1:0]   conv_b,
  output logic [15:0]              conv_meta,
  output logic                     conv_enable,
  output logic                     conv_owner,
  output logic                     yuv_owner,
  output logic                     frame_abort,
  output logic [15:0]              frame_cnt0,
  output logic [15:0]              frame_cnt1
);

  localparam int CNT_W = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    last_owner_q, last_owner_d;
  logic                    enable_q, enable_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    conv_dv_q;
  logic [`DTYPE_WIDTH-1:0] conv_dtype_q;
  logic [PIXEL_WIDTH-1:0]  conv_r_q, conv_g_q, conv_b_q;
  logic [15:0]             conv_meta_q;
  logic                    conv_owner_q;
  logic                    yuv_owner_q;
  logic [15:0]             frame_cnt0_q, frame_cnt1_q;

  // Combinational decisions for the current cycle.
  logic                    rdy0, rdy1;
  logic                    fwd;        // accepted beat goes to the converter
  logic                    sel;        // stream whose beat is forwarded / owner
  logic                    abort;
  logic [1:0]              frame_done; // bit k: eof of stream k accepted
  logic                    req0, req1;
  logic                    own_dv, own_eof, win_eof;

  // NOTE: every signal written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    enable_d     = enable_q;
    cnt_d        = cnt_q;
    rdy0         = 1'b0;
    rdy1         = 1'b0;
    fwd          = 1'b0;
    sel          = 1'b0;
    abort        = 1'b0;
    frame_done   = 2'b00;
    req0         = s0.dv && s0.sof;
    req1         = s1.dv && s1.sof;
    own_dv       = 1'b0;
    own_eof      = 1'b0;
    win_eof      = 1'b0;

    // While reset is held nothing is accepted, so rdy stays low too.
    if (!reset) begin
      unique case (state_q)
        ST_IDLE: begin
          // Beats outside a frame are swallowed so a stream resyncs at sof.
          if (s0.dv && !s0.sof) rdy0 = 1'b1;
          if (s1.dv && !s1.sof) rdy1 = 1'b1;
          if (req0 || req1) begin
            // Contention goes to the stream that did not own the last frame.
            sel      = (req0 && req1) ? ~last_owner_q : req1;
            fwd      = 1'b1;
            enable_d = csc_en[sel];
            win_eof  = sel ? s1.eof : s0.eof;
            if (sel) rdy1 = 1'b1;
            else     rdy0 = 1'b1;
            if (win_eof) begin
              // Single-beat frame: ownership never leaves IDLE.
              last_owner_d    = sel;
              frame_done[sel] = 1'b1;
            end else begin
              state_d = sel ? ST_OWN1 : ST_OWN0;
            end
          end
        end
        ST_OWN0, ST_OWN1: begin
          sel     = (state_q == ST_OWN1);
          own_dv  = sel ? s1.dv  : s0.dv;
          own_eof = sel ? s1.eof : s0.eof;
          if (sel) rdy1 = 1'b1;
          else     rdy0 = 1'b1;
          if (own_dv) begin
            fwd   = 1'b1;
            cnt_d = '0;
            if (own_eof) begin
              state_d         = ST_IDLE;
              last_owner_d    = sel;
              frame_done[sel] = 1'b1;
            end
          end else if (cnt_q == CNT_LAST) begin
            // Owner stalled too long: drop the frame and rotate priority.
            state_d      = ST_IDLE;
            last_owner_d = sel;
            abort        = 1'b1;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      enable_q     <= 1'b0;
      cnt_q        <= '0;
      conv_dv_q    <= 1'b0;
      conv_dtype_q <= '0;
      conv_r_q     <= '0;
      conv_g_q     <= '0;
      conv_b_q     <= '0;
      conv_meta_q  <= '0;
      conv_owner_q <= 1'b0;
      yuv_owner_q  <= 1'b0;
      frame_cnt0_q <= '0;
      frame_cnt1_q <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      enable_q     <= enable_d;
      cnt_q        <= cnt_d;
      conv_dv_q    <= fwd;
      yuv_owner_q  <= conv_owner_q;
      if (fwd) begin
        conv_owner_q <= sel;
        conv_dtype_q <= sel ? s1.dtype : s0.dtype;
        conv_r_q     <= sel ? s1.r     : s0.r;
        conv_g_q     <= sel ? s1.g     : s0.g;
        conv_b_q     <= sel ? s1.b     : s0.b;
        conv_meta_q  <= sel ? s1.meta  : s0.meta;
      end
      if (frame_done[0]) frame_cnt0_q <= frame_cnt0_q + 16'd1;
      if (frame_done[1]) frame_cnt1_q <= frame_cnt1_q + 16'd1;
    end
  end

  assign s0.rdy      = rdy0;
  assign s1.rdy      = rdy1;
  assign conv_dv     = conv_dv_q;
  assign conv_dtype  = conv_dtype_q;
  assign conv_r      = conv_r_q;
  assign conv_g      = conv_g_q;
  assign conv_b      = conv_b_q;
  assign conv_meta   = conv_meta_q;
  assign conv_enable = enable_q;
  assign conv_owner  = conv_owner_q;
  assign yuv_owner   = yuv_owner_q;
  assign frame_abort = abort;
  assign frame_cnt0  = frame_cnt0_q;
  assign frame_cnt1  = frame_cnt1_q;

endmodule

// File: tb/tb_rgb2yuv_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rgb2yuv_frame_arbiter
//   Directed, table-driven bench for rgb2yuv_frame_arbiter (IDLE_TIMEOUT=8).
//   Each record gives one cycle of stream inputs plus the expected
//   combinational outputs in that cycle and registered outputs after the edge.
//   Reset-mid-frame is a hand-written sequence at the end.
// ---------------------------------------------------------------------------
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif

module tb_rgb2yuv_frame_arbiter;

  localparam int PW = 8;

  // Beat flags {dv, sof, eof}
  localparam logic [2:0] NO = 3'b000;
  localparam logic [2:0] SF = 3'b110;
  localparam logic [2:0] MD = 3'b100;
  localparam logic [2:0] EF = 3'b101;
  localparam logic [2:0] SE = 3'b111;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [1:0]              csc_en = 2'b00;
  logic                    conv_dv, conv_enable, conv_owner, yuv_owner, frame_abort;
  logic [`DTYPE_WIDTH-1:0] conv_dtype;
  logic [PW-1:0]           conv_r, conv_g, conv_b;
  logic [15:0]             conv_meta, frame_cnt0, frame_cnt1;

  int total = 0;
  int bad   = 0;

  rgb2yuv_frame_arbiter_if #(.PIXEL_WIDTH(PW)) s0_if ();
  rgb2yuv_frame_arbiter_if #(.PIXEL_WIDTH(PW)) s1_if ();

  rgb2yuv_frame_arbiter #(.PIXEL_WIDTH(PW), .IDLE_TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .csc_en      (csc_en),
    .s0          (s0_if.slave),
    .s1          (s1_if.slave),
    .conv_dv     (conv_dv),
    .conv_dtype  (conv_dtype),
    .conv_r      (conv_r),
    .conv_g      (conv_g),
    .conv_b      (conv_b),
    .conv_meta   (conv_meta),
    .conv_enable (conv_enable),
    .conv_owner  (conv_owner),
    .yuv_owner   (yuv_owner),
    .frame_abort (frame_abort),
    .frame_cnt0  (frame_cnt0),
    .frame_cnt1  (frame_cnt1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached (actual=running required=finished)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         rst;   // pulse reset before this cycle
    logic [1:0] csc;
    logic [2:0] f0;
    logic [7:0] d0;
    logic [2:0] f1;
    logic [7:0] d1;
    logic [1:0] rdy;   // {rdy1, rdy0}
    logic       abort;
    logic       dv;
    logic       own;
    logic       en;
    logic [7:0] r;     // data checked only when dv expected
    logic       yown;
    logic [15:0] c0;
    logic [15:0] c1;
  } vec_t;

  vec_t vq[$];

  function automatic void v(bit rst, logic [1:0] csc, logic [2:0] f0, logic [7:0] d0,
                            logic [2:0] f1, logic [7:0] d1, logic [1:0] rdy, logic abort,
                            logic dv, logic own, logic en, logic [7:0] r, logic yown,
                            logic [15:0] c0, logic [15:0] c1);
    vec_t t;
    t.rst = rst; t.csc = csc; t.f0 = f0; t.d0 = d0; t.f1 = f1; t.d1 = d1;
    t.rdy = rdy; t.abort = abort; t.dv = dv; t.own = own; t.en = en;
    t.r = r; t.yown = yown; t.c0 = c0; t.c1 = c1;
    vq.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Other beat fields are derived from r so a wrong mux leg shows up.
  task automatic apply(input logic [2:0] f0, input logic [7:0] d0,
                       input logic [2:0] f1, input logic [7:0] d1, input logic [1:0] csc);
    @(negedge clk);
    csc_en = csc;
    {s0_if.dv, s0_if.sof, s0_if.eof} = f0;
    s0_if.r = d0; s0_if.g = d0 + 8'd1; s0_if.b = d0 ^ 8'hFF;
    s0_if.dtype = d0 ^ 8'h3C; s0_if.meta = {d0, ~d0};
    {s1_if.dv, s1_if.sof, s1_if.eof} = f1;
    s1_if.r = d1; s1_if.g = d1 + 8'd1; s1_if.b = d1 ^ 8'hFF;
    s1_if.dtype = d1 ^ 8'h3C; s1_if.meta = {d1, ~d1};
    #1;
  endtask

  task automatic apply_reset();
    apply(NO, 8'h00, NO, 8'h00, 2'b00);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_data(input string tag, input logic [7:0] r);
    logic [7:0] nr;
    nr = ~r;
    check({tag, " conv_r"},     32'(conv_r),     32'(r));
    check({tag, " conv_g"},     32'(conv_g),     32'(r + 8'd1));
    check({tag, " conv_b"},     32'(conv_b),     32'(r ^ 8'hFF));
    check({tag, " conv_dtype"}, 32'(conv_dtype), 32'(r ^ 8'h3C));
    check({tag, " conv_meta"},  32'(conv_meta),  32'({r, nr}));
  endtask

  initial begin
    // Test 1: s0 frame sof + 3 beats + eof, csc_en=01.
    v(0, 2'b01, SF, 8'h80, NO, 8'h00, 2'b01, 0, 1, 0, 1, 8'h80, 0, 0, 0);
    v(0, 2'b01, MD, 8'h80, NO, 8'h00, 2'b01, 0, 1, 0, 1, 8'h80, 0, 0, 0);
    v(0, 2'b01, MD, 8'h80, NO, 8'h00, 2'b01, 0, 1, 0, 1, 8'h80, 0, 0, 0);
    v(0, 2'b01, MD, 8'h80, NO, 8'h00, 2'b01, 0, 1, 0, 1, 8'h80, 0, 0, 0);
    v(0, 2'b01, EF, 8'h80, NO, 8'h00, 2'b01, 0, 1, 0, 1, 8'h80, 0, 1, 0);
    v(0, 2'b01, NO, 8'h00, NO, 8'h00, 2'b00, 0, 0, 0, 1, 8'h00, 0, 1, 0);
    // Test 2: contention after reset, round-robin.
    v(1, 2'b11, SF, 8'h10, SF, 8'h20, 2'b01, 0, 1, 0, 1, 8'h10, 0, 0, 0);
    v(0, 2'b11, EF, 8'h11, SF, 8'h20, 2'b01, 0, 1, 0, 1, 8'h11, 0, 1, 0);
    v(0, 2'b11, NO, 8'h00, SF, 8'h20, 2'b10, 0, 1, 1, 1, 8'h20, 0, 1, 0);
    v(0, 2'b11, SF, 8'h12, EF, 8'h21, 2'b10, 0, 1, 1, 1, 8'h21, 1, 1, 1);
    v(0, 2'b11, SF, 8'h12, SF, 8'h22, 2'b01, 0, 1, 0, 1, 8'h12, 1, 1, 1);
    v(0, 2'b11, EF, 8'h13, SF, 8'h22, 2'b01, 0, 1, 0, 1, 8'h13, 0, 2, 1);
    v(0, 2'b11, NO, 8'h00, SE, 8'h23, 2'b10, 0, 1, 1, 1, 8'h23, 0, 2, 2);
    v(0, 2'b11, NO, 8'h00, NO, 8'h00, 2'b00, 0, 0, 1, 1, 8'h00, 1, 2, 2);
    // Test 3: drops in IDLE, enable frozen at grant.
    v(1, 2'b11, SE, 8'h2F, NO, 8'h00, 2'b01, 0, 1, 0, 1, 8'h2F, 0, 1, 0);
    v(0, 2'b11, NO, 8'h00, MD, 8'h30, 2'b10, 0, 0, 0, 1, 8'h00, 0, 1, 0);
    v(0, 2'b11, NO, 8'h00, EF, 8'h31, 2'b10, 0, 0, 0, 1, 8'h00, 0, 1, 0);
    v(0, 2'b01, NO, 8'h00, SF, 8'h32, 2'b10, 0, 1, 1, 0, 8'h32, 0, 1, 0);
    v(0, 2'b11, NO, 8'h00, MD, 8'h33, 2'b10, 0, 1, 1, 0, 8'h33, 1, 1, 0);
    v(0, 2'b10, NO, 8'h00, MD, 8'h34, 2'b10, 0, 1, 1, 0, 8'h34, 1, 1, 0);
    v(0, 2'b11, NO, 8'h00, EF, 8'h35, 2'b10, 0, 1, 1, 0, 8'h35, 1, 1, 1);
    // Test 5: single-beat frame stays IDLE, then s1 wins contention.
    v(1, 2'b01, SE, 8'h50, NO, 8'h00, 2'b01, 0, 1, 0, 1, 8'h50, 0, 1, 0);
    v(0, 2'b01, SF, 8'h51, SF, 8'h60, 2'b10, 0, 1, 1, 0, 8'h60, 0, 1, 0);
    v(0, 2'b01, SF, 8'h51, EF, 8'h61, 2'b10, 0, 1, 1, 0, 8'h61, 1, 1, 1);
    v(0, 2'b01, SE, 8'h51, NO, 8'h00, 2'b01, 0, 1, 0, 1, 8'h51, 1, 2, 1);
    // Test 4: timeout after 8 idle cycles; pending s1 granted next cycle.
    v(1, 2'b11, SF, 8'h40, NO, 8'h00, 2'b01, 0, 1, 0, 1, 8'h40, 0, 0, 0);
    for (int k = 0; k < 7; k++)
      v(0, 2'b11, NO, 8'h00, SF, 8'h70, 2'b01, 0, 0, 0, 1, 8'h00, 0, 0, 0);
    v(0, 2'b11, NO, 8'h00, SF, 8'h70, 2'b01, 1, 0, 0, 1, 8'h00, 0, 0, 0);
    v(0, 2'b11, NO, 8'h00, SF, 8'h70, 2'b10, 0, 1, 1, 1, 8'h70, 0, 0, 0);
    v(0, 2'b11, NO, 8'h00, EF, 8'h71, 2'b10, 0, 1, 1, 1, 8'h71, 1, 0, 1);
    // 7 idle cycles then a beat: just under the limit, no abort.
    v(0, 2'b11, SF, 8'h42, NO, 8'h00, 2'b01, 0, 1, 0, 1, 8'h42, 1, 0, 1);
    for (int k = 0; k < 7; k++)
      v(0, 2'b11, NO, 8'h00, NO, 8'h00, 2'b01, 0, 0, 0, 1, 8'h00, 0, 0, 1);
    v(0, 2'b11, EF, 8'h43, NO, 8'h00, 2'b01, 0, 1, 0, 1, 8'h43, 0, 1, 1);

    // Reset state
    {s0_if.dv, s0_if.sof, s0_if.eof} = NO;
    {s1_if.dv, s1_if.sof, s1_if.eof} = NO;
    s0_if.r = '0; s0_if.g = '0; s0_if.b = '0; s0_if.dtype = '0; s0_if.meta = '0;
    s1_if.r = '0; s1_if.g = '0; s1_if.b = '0; s1_if.dtype = '0; s1_if.meta = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset conv_dv",     32'(conv_dv),     0);
    check("reset conv_enable", 32'(conv_enable), 0);
    check("reset conv_owner",  32'(conv_owner),  0);
    check("reset conv_r",      32'(conv_r),      0);
    check("reset frame_cnt0",  32'(frame_cnt0),  0);
    check("reset frame_cnt1",  32'(frame_cnt1),  0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      if (vq[i].rst) apply_reset();
      apply(vq[i].f0, vq[i].d0, vq[i].f1, vq[i].d1, vq[i].csc);
      check({tag, " rdy0"},        32'(s0_if.rdy),   32'(vq[i].rdy[0]));
      check({tag, " rdy1"},        32'(s1_if.rdy),   32'(vq[i].rdy[1]));
      check({tag, " frame_abort"}, 32'(frame_abort), 32'(vq[i].abort));
      @(posedge clk);
      #1;
      check({tag, " conv_dv"},     32'(conv_dv),     32'(vq[i].dv));
      check({tag, " conv_owner"},  32'(conv_owner),  32'(vq[i].own));
      check({tag, " conv_enable"}, 32'(conv_enable), 32'(vq[i].en));
      check({tag, " yuv_owner"},   32'(yuv_owner),   32'(vq[i].yown));
      check({tag, " frame_cnt0"},  32'(frame_cnt0),  32'(vq[i].c0));
      check({tag, " frame_cnt1"},  32'(frame_cnt1),  32'(vq[i].c1));
      if (vq[i].dv) check_data(tag, vq[i].r);
    end

    // Test 6: reset asserted mid-frame in OWN_1, then resync at next sof.
    apply(NO, 8'h00, SF, 8'h90, 2'b10);
    @(posedge clk); #1;
    check("t6 grant conv_owner", 32'(conv_owner), 1);
    apply(NO, 8'h00, MD, 8'h91, 2'b10);
    @(posedge clk); #1;
    check("t6 mid conv_dv", 32'(conv_dv), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6 rst conv_dv",     32'(conv_dv),     0);
    check("t6 rst conv_owner",  32'(conv_owner),  0);
    check("t6 rst conv_enable", 32'(conv_enable), 0);
    check("t6 rst conv_r",      32'(conv_r),      0);
    check("t6 rst yuv_owner",   32'(yuv_owner),   0);
    check("t6 rst rdy1",        32'(s1_if.rdy),   0);
    check("t6 rst frame_cnt0",  32'(frame_cnt0),  0);
    check("t6 rst frame_cnt1",  32'(frame_cnt1),  0);
    @(negedge clk);
    reset = 1'b0;
    apply(NO, 8'h00, MD, 8'h92, 2'b10);
    check("t6 drop rdy1", 32'(s1_if.rdy), 1);
    @(posedge clk); #1;
    check("t6 drop conv_dv", 32'(conv_dv), 0);
    apply(NO, 8'h00, EF, 8'h93, 2'b10);
    check("t6 drop eof rdy1", 32'(s1_if.rdy), 1);
    @(posedge clk); #1;
    check("t6 drop eof conv_dv",    32'(conv_dv),    0);
    check("t6 drop eof frame_cnt1", 32'(frame_cnt1), 0);
    apply(NO, 8'h00, SF, 8'h94, 2'b10);
    @(posedge clk); #1;
    check("t6 resync conv_dv",     32'(conv_dv),     1);
    check("t6 resync conv_owner",  32'(conv_owner),  1);
    check("t6 resync conv_enable", 32'(conv_enable), 1);
    check_data("t6 resync", 8'h94);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
